lsu_byte_master: RTL and testbench

Load/store initiator that sits between the single-cycle CPU's execute stage and the byte-addressed data memory. It accepts one load or store request at a time, using RISC-V funct3 encoding, and checks size and alignment. It serialises the access into one-byte-per-cycle memory transactions, then returns sign- or zero-extended load data or store completion through a one-cycle response strobe.

---
 rtl/lsu_byte_master_if.sv | 29 ++
 rtl/lsu_byte_master.sv | 175 +++++++++++++++++
 tb/tb_lsu_byte_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_byte_master_if.sv
// rtl/lsu_byte_master_if.sv - request, response and byte-memory bundle for the load/store initiator
interface lsu_byte_master_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_master.sv
// rtl/lsu_byte_master.sv - load/store initiator serialising RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into byte accesses
module lsu_byte_master #(
  parameter int ADDR_W        = 7,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic               clk,
  input logic               rstn,
  lsu_byte_master_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              req_legal;
  logic              req_misal;
  logic [31:0]       buf_nxt;
  logic [1:0]        k_inc;
  logic [ADDR_W-1:0] addr_nxt;

  function automatic logic [1:0] last_k(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic we, input logic [2:0] f3, input logic [31:0] b);
    if (we) begin
      extend = 32'd0;
    end else begin
      case (f3)
        3'b000:  extend = {{24{b[7]}}, b[7:0]};
        3'b100:  extend = {24'd0, b[7:0]};
        3'b001:  extend = {{16{b[15]}}, b[15:0]};
        3'b101:  extend = {16'd0, b[15:0]};
        default: extend = b;
      endcase
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    we_d        = we_q;
    f3_d        = f3_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = 8'd0;

    req_legal = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                           : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    req_misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    // mem_rdata answers the address registered for this cycle, so byte k lands here
    buf_nxt = buf_q;
    if (!we_q) buf_nxt[{k_q, 3'b000} +: 8] = bus.mem_rdata;
    k_inc    = k_q + 2'd1;
    addr_nxt = base_q + ADDR_W'(k_inc);

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          base_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          k_d     = 2'd0;
          buf_d   = 32'd0;
          if (!req_legal || (MISALIGN_TRAP && req_misal)) begin
            state_d     = S_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = S_XFER;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata[7:0];
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_XFER: begin
        buf_d = buf_nxt;
        if (k_q == last_k(f3_q)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = extend(we_q, f3_q, buf_nxt);
        end else begin
          k_d         = k_inc;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_nxt;
          mem_wdata_d = wdata_q[{k_inc, 3'b000} +: 8];
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      k_q         <= 2'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb/tb_lsu_byte_master.sv - bench for lsu_byte_master with trapping and bytewise-misaligned instances
module tb_lsu_byte_master;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_s;

  typedef struct {
    logic        s;
    logic        we;
    logic [2:0]  f3;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic        eerr;
    logic [31:0] erd;
    int          lat;
  } vec_t;

  logic clk;
  logic rstn;
  logic sel;
  logic rv_t, rv_w, r_we;
  logic [2:0]  r_f3;
  logic [6:0]  r_addr;
  logic [31:0] r_wd;
  int n_vec = 0;
  int n_bad = 0;
  int rsp_cnt_t = 0;
  int rsp_cnt_w = 0;
  exp_s exp_q_t[$];
  exp_s exp_q_w[$];
  logic [6:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [7:0] mem_t [0:127];
  logic [7:0] mem_w [0:127];

  lsu_byte_master_if #(.ADDR_W(7)) if_t ();
  lsu_byte_master_if #(.ADDR_W(7)) if_w ();

  lsu_byte_master #(.ADDR_W(7), .MISALIGN_TRAP(1'b1)) u_trap (.clk(clk), .rstn(rstn), .bus(if_t));
  lsu_byte_master #(.ADDR_W(7), .MISALIGN_TRAP(1'b0)) u_wrap (.clk(clk), .rstn(rstn), .bus(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign if_t.req_valid = rv_t;
  assign if_w.req_valid = rv_w;
  assign if_t.req_we = r_we;
  assign if_w.req_we = r_we;
  assign if_t.req_funct3 = r_f3;
  assign if_w.req_funct3 = r_f3;
  assign if_t.req_addr = r_addr;
  assign if_w.req_addr = r_addr;
  assign if_t.req_wdata = r_wd;
  assign if_w.req_wdata = r_wd;

  // byte memories with combinational read
  always @(posedge clk) if (if_t.mem_en && if_t.mem_we) mem_t[if_t.mem_addr] <= if_t.mem_wdata;
  always @(posedge clk) if (if_w.mem_en && if_w.mem_we) mem_w[if_w.mem_addr] <= if_w.mem_wdata;
  assign if_t.mem_rdata = mem_t[if_t.mem_addr];
  assign if_w.mem_rdata = mem_w[if_w.mem_addr];

  logic cur_ready, cur_rsp_valid, cur_err, cur_mem_en, cur_mem_we;
  logic [31:0] cur_rdata;
  logic [6:0]  cur_mem_addr;
  logic [7:0]  cur_mem_wdata;
  assign cur_ready     = sel ? if_w.req_ready : if_t.req_ready;
  assign cur_rsp_valid = sel ? if_w.rsp_valid : if_t.rsp_valid;
  assign cur_err       = sel ? if_w.rsp_err   : if_t.rsp_err;
  assign cur_rdata     = sel ? if_w.rsp_rdata : if_t.rsp_rdata;
  assign cur_mem_en    = sel ? if_w.mem_en    : if_t.mem_en;
  assign cur_mem_we    = sel ? if_w.mem_we    : if_t.mem_we;
  assign cur_mem_addr  = sel ? if_w.mem_addr  : if_t.mem_addr;
  assign cur_mem_wdata = sel ? if_w.mem_wdata : if_t.mem_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_s e;
    if (if_t.rsp_valid) begin
      rsp_cnt_t++;
      if (exp_q_t.size() == 0) check("rsp_unexpected_t", if_t.rsp_valid, 1'b0);
      else begin
        e = exp_q_t.pop_front();
        check("rsp_err_t", if_t.rsp_err, e.err);
        check("rsp_rdata_t", if_t.rsp_rdata, e.rdata);
      end
    end
    if (if_w.rsp_valid) begin
      rsp_cnt_w++;
      if (exp_q_w.size() == 0) check("rsp_unexpected_w", if_w.rsp_valid, 1'b0);
      else begin
        e = exp_q_w.pop_front();
        check("rsp_err_w", if_w.rsp_err, e.err);
        check("rsp_rdata_w", if_w.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic check_reset_vals(input logic s);
    sel = s;
    #1;
    check("rst_req_ready", cur_ready, 1'b1);
    check("rst_rsp_valid", cur_rsp_valid, 1'b0);
    check("rst_rsp_err", cur_err, 1'b0);
    check("rst_rsp_rdata", cur_rdata, 32'd0);
    check("rst_mem_en", cur_mem_en, 1'b0);
    check("rst_mem_we", cur_mem_we, 1'b0);
    check("rst_mem_addr", cur_mem_addr, 7'd0);
    check("rst_mem_wdata", cur_mem_wdata, 8'd0);
  endtask

  // call at a negedge; returns at the negedge of the cycle after the response
  task automatic issue(input vec_t v);
    int w;
    int lat;
    int en_cnt;
    sel = v.s;
    r_we = v.we; r_f3 = v.f3; r_addr = v.addr; r_wd = v.wd;
    if (v.s) rv_w = 1'b1; else rv_t = 1'b1;
    #1;
    w = 0;
    while (!cur_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cur_ready) begin
      check("accept_timeout", cur_ready, 1'b1);
      rv_t = 1'b0; rv_w = 1'b0;
      return;
    end
    if (v.s) exp_q_w.push_back('{v.eerr, v.erd});
    else     exp_q_t.push_back('{v.eerr, v.erd});
    @(posedge clk);
    #1;
    rv_t = 1'b0; rv_w = 1'b0;
    lat = 0; en_cnt = 0;
    wr_a.delete(); wr_d.delete();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (cur_mem_en) begin
        en_cnt++;
        if (cur_mem_we) begin
          wr_a.push_back(cur_mem_addr);
          wr_d.push_back(cur_mem_wdata);
        end
      end
      if (cur_rsp_valid) begin
        lat = c;
        break;
      end
    end
    check("rsp_latency", lat, v.lat);
    check("mem_en_cycles", en_cnt, v.eerr ? 0 : v.lat - 1);
    @(negedge clk);
    check("ready_after_rsp", cur_ready, 1'b1);
    check("rsp_one_cycle", cur_rsp_valid, 1'b0);
    check("rsp_err_hold", cur_err, v.eerr);
    check("rsp_rdata_hold", cur_rdata, v.erd);
  endtask

  task automatic check_wr(input logic [6:0] base, input logic [31:0] d);
    logic [31:0] dv;
    dv = d;
    check("wr_count", wr_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_a.size()) begin
        check("wr_addr", wr_a[i], 7'(base + 7'(i)));
        check("wr_byte", wr_d[i], dv[8*i +: 8]);
      end
    end
  endtask

  function automatic vec_t mk(input logic s, input logic we, input logic [2:0] f3, input logic [6:0] addr,
                              input logic [31:0] wd, input logic eerr, input logic [31:0] erd, input int lat);
    vec_t v;
    v.s = s; v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.eerr = eerr; v.erd = erd; v.lat = lat;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int acc[$];
    int r0;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int acc[$];
    int r0;
    vecs.push_back(mk(0, 0, 3'b010, 7'h10, 32'h0, 0, 32'hDEADBEEF, 5));
    vecs.push_back(mk(0, 0, 3'b000, 7'h13, 32'h0, 0, 32'hFFFFFFDE, 2));
    vecs.push_back(mk(0, 0, 3'b100, 7'h13, 32'h0, 0, 32'h000000DE, 2));
    vecs.push_back(mk(0, 0, 3'b001, 7'h12, 32'h0, 0, 32'hFFFFDEAD, 3));
    vecs.push_back(mk(0, 0, 3'b101, 7'h10, 32'h0, 0, 32'h0000BEEF, 3));
    vecs.push_back(mk(0, 0, 3'b000, 7'h10, 32'h0, 0, 32'hFFFFFFEF, 2));
    vecs.push_back(mk(0, 0, 3'b001, 7'h11, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 3'b010, 7'h12, 32'h55555555, 1, 32'h0, 1));
    vecs.push_back(mk(0, 0, 3'b010, 7'h11, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 0, 3'b011, 7'h10, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 3'b011, 7'h10, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 3'b100, 7'h10, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 0, 3'b111, 7'h10, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 1, 3'b000, 7'h11, 32'h1234567F, 0, 32'h0, 2));
    vecs.push_back(mk(0, 1, 3'b001, 7'h12, 32'hCAFE8001, 0, 32'h0, 3));
    vecs.push_back(mk(0, 0, 3'b010, 7'h10, 32'h0, 0, 32'h80017FEF, 5));
    vecs.push_back(mk(0, 0, 3'b001, 7'h12, 32'h0, 0, 32'hFFFF8001, 3));
    vecs.push_back(mk(0, 0, 3'b101, 7'h12, 32'h0, 0, 32'h00008001, 3));
    vecs.push_back(mk(0, 0, 3'b000, 7'h11, 32'h0, 0, 32'h0000007F, 2));
    vecs.push_back(mk(1, 0, 3'b010, 7'h7E, 32'h0, 0, 32'h11223344, 5));
    vecs.push_back(mk(1, 0, 3'b001, 7'h7F, 32'h0, 0, 32'h00002233, 3));
    vecs.push_back(mk(1, 0, 3'b101, 7'h00, 32'h0, 0, 32'h00001122, 3));
    vecs.push_back(mk(1, 0, 3'b100, 7'h7F, 32'h0, 0, 32'h00000033, 2));
    vecs.push_back(mk(1, 0, 3'b000, 7'h01, 32'h0, 0, 32'h00000011, 2));
    vecs.push_back(mk(1, 0, 3'b011, 7'h00, 32'h0, 1, 32'h0, 1));
    vecs.push_back(mk(1, 1, 3'b110, 7'h00, 32'h0, 1, 32'h0, 1));

    rstn = 1'b0; sel = 1'b0; rv_t = 1'b0; rv_w = 1'b0;
    r_we = 1'b0; r_f3 = 3'd0; r_addr = 7'd0; r_wd = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_vals(1'b0);
    check_reset_vals(1'b1);
    rstn = 1'b1;
    @(negedge clk);

    issue(mk(0, 1, 3'b010, 7'h10, 32'hDEADBEEF, 0, 32'h0, 5));
    check_wr(7'h10, 32'hDEADBEEF);
    issue(mk(1, 1, 3'b010, 7'h7E, 32'h11223344, 0, 32'h0, 5));
    check_wr(7'h7E, 32'h11223344);

    foreach (vecs[i]) issue(vecs[i]);

    // store aborted by reset after two byte writes
    issue(mk(1, 1, 3'b010, 7'h20, 32'h0, 0, 32'h0, 5));
    sel = 1'b1;
    r_we = 1'b1; r_f3 = 3'b010; r_addr = 7'h20; r_wd = 32'hAABBCCDD;
    rv_w = 1'b1;
    @(posedge clk);
    #1 rv_w = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("rst_async_mem_en", if_w.mem_en, 1'b0);
    check_reset_vals(1'b1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rsp", if_w.rsp_valid, 1'b0);
    end
    check("rst_partial_mem", {mem_w[7'h23], mem_w[7'h22], mem_w[7'h21], mem_w[7'h20]}, 32'h0000CCDD);
    issue(mk(1, 0, 3'b010, 7'h20, 32'h0, 0, 32'h0000CCDD, 5));

    // req_valid held high with LB requests
    sel = 1'b0;
    r_we = 1'b0; r_f3 = 3'b000; r_addr = 7'h10; r_wd = 32'd0;
    r0 = rsp_cnt_t;
    rv_t = 1'b1;
    #1;
    for (int i = 0; i < 18; i++) begin
      if (cur_ready) begin
        exp_q_t.push_back('{1'b0, 32'hFFFFFFEF});
        acc.push_back(i);
      end
      @(negedge clk);
    end
    rv_t = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_accepts", acc.size(), 6);
    for (int i = 1; i < acc.size(); i++) check("b2b_spacing", acc[i] - acc[i-1], 3);
    check("b2b_rsp_count", rsp_cnt_t - r0, 6);

    check("queue_drained_t", exp_q_t.size(), 0);
    check("queue_drained_w", exp_q_w.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
